ft_uart_marker_tx: RTL and testbench
====================================

# ft_uart_marker_tx

Injects FreezeTime marker words into the SoC UART transmit byte stream so the FreezeTime UART trigger decoder downstream fires `sim_start`, `sim_end` or `sim_proc` without software involvement. It sits in front of the UART TX FIFO write port, muxed with the CPU write path. Single-cycle requests from control logic are latched, arbitrated, and serialised as four-byte markers under valid/ready backpressure.

## Interface
- `MARKER_LEN`, 4: bytes per marker, excluding the optional trailer.
- `clock`  in  1  module clock.
- `reset`  in  1  **asynchronous, active-low** reset.
- `req_start`  in  1  one-cycle request to send the start marker.
- `req_end`  in  1  one-cycle request to send the end marker.
- `req_proc`  in  1  one-cycle request to send the proc marker.
- `tx_payload`  out  8  byte being offered to the TX FIFO.
- `tx_valid`  out  1  `tx_payload` is valid.
- `tx_ready`  in  1  TX FIFO accepts the byte (not full).
- `busy`  out  1  FSM is not in IDLE.
- `pending`  out  3  latched requests, ordered {proc, end, start}.
- `drop_count`  out  8  saturating count of coalesced requests.

## Operation
- Marker bytes:
  - start: 0x41 0x42 0x43 0x44
  - end: 0x45 0x46 0x47 0x48
  - proc: 0x70 0x72 0x6F 0x63
- Request latching: a `req_*` high at a clock edge sets its `pending` bit.
  - If that bit is already set, the request is coalesced and `drop_count` increments, saturating at 255.
  - Simultaneous requests for different markers set all their bits with no drops.
- Arbitration, in IDLE only: fixed priority end > start > proc.
  - The winner's `pending` bit clears on the same edge that loads its id into the FSM.
  - A new request for the marker currently in flight sets `pending` again, so that marker is sent again.
- FSM states:
  - IDLE → SEND on any pending bit; byte index = 0.
  - SEND: presents byte[index] on `tx_payload`. On `tx_valid && tx_ready`: if index < `MARKER_LEN`-1, index increments; otherwise → TRAIL when the trailer is compiled in, else → IDLE.
  - TRAIL: sends 0x0D then 0x0A under the same handshake, then → IDLE.
- Handshake rules:
  - `tx_valid` is never withdrawn, and `tx_payload` never changes, until the byte is accepted.
  - `tx_ready` is ignored while `tx_valid` is low.
- Reset, asynchronous: all outputs go to 0 immediately, and the FSM returns to IDLE.
  - A partially sent marker is abandoned. The decoder resets its own match on the next mismatching byte.

## Timing
- `req_*` high at edge N → `pending` set after edge N → FSM leaves IDLE at edge N+1. `tx_valid` = 1 and byte 0 are presented in cycle N+1→N+2.
- With `tx_ready` held high, one byte is accepted per cycle, so a marker occupies 4 consecutive cycles (6 with the trailer).
- After the last byte is accepted the FSM spends exactly one cycle in IDLE with `tx_valid` low before the next marker starts. Markers are therefore never interleaved or adjacent.
- All outputs are registered; there is no combinational path from `req_*` or `tx_ready` to any output.
- Reset values:
  - `tx_payload` = 0x00
  - `tx_valid` = 0
  - `busy` = 0
  - `pending` = 3'b000
  - `drop_count` = 0

## Configuration
- `FT_MARKER_CRLF_EN`:
  - Defined: TRAIL state exists, and 0x0D 0x0A is appended after each marker so console logs stay line-separated.
  - Undefined: TRAIL is not compiled, and SEND returns directly to IDLE after byte `MARKER_LEN`-1.

## Structure
- Package `ft_marker_pkg` holds:
  - marker id enum {MK_START, MK_END, MK_PROC};
  - the 4×8 byte constants for each marker;
  - `FT_MARKER_LEN` = 4;
  - CR/LF constants, shared with the trigger decoder so both ends agree.
- Sub-module `ft_marker_rom`: combinational lookup (id, index) → byte, reusable by the decoder.
- FSM, pending latches and drop counter live in the top module.

## Test plan
- Single `req_start` pulse, `tx_ready`=1 → bytes 0x41,0x42,0x43,0x44 on four consecutive cycles starting 2 cycles after the request; `busy` returns to 0.
- `req_start`, `req_end` and `req_proc` in the same cycle → order end, start, proc; one idle cycle between markers; `drop_count` stays 0.
- `req_proc`, then `tx_ready` held low 10 cycles after byte 0 → `tx_valid`=1 and `tx_payload`=0x70 held stable throughout; the stream resumes 0x72,0x6F,0x63.
- Three `req_end` pulses while the end marker is pending (before it is loaded) → one end marker sent and `drop_count`=2. A further 300 coalesced requests → `drop_count` saturates at 255.
- Reset asserted after byte 1 of the start marker → `tx_valid`, `pending` and `busy` drop to 0 asynchronously. After release, a fresh `req_start` sends a full 0x41..0x44.
- With `FT_MARKER_CRLF_EN` defined, `req_end` → 0x45,0x46,0x47,0x48,0x0D,0x0A. Loop the output into the trigger decoder and check `sim_end` asserts after 0x48.

Source files
------------

// File: rtl/ft_marker_pkg.sv
// Shared FreezeTime marker definitions: ids, byte patterns and CR/LF trailer bytes,
// used by both the marker injector and the trigger decoder. FSM states depend on FT_MARKER_CRLF_EN.
package ft_marker_pkg;

  localparam int unsigned FT_MARKER_LEN = 4;
  localparam int unsigned FT_IDX_W      = $clog2(FT_MARKER_LEN);
  localparam int unsigned FT_BYTE_W     = 8;

  typedef enum logic [1:0] {
    MK_START = 2'd0,
    MK_END   = 2'd1,
    MK_PROC  = 2'd2
  } mk_id_e;

  // Element [0] is the first byte on the wire
  localparam logic [FT_MARKER_LEN-1:0][FT_BYTE_W-1:0] FT_START_BYTES = {8'h44, 8'h43, 8'h42, 8'h41};
  localparam logic [FT_MARKER_LEN-1:0][FT_BYTE_W-1:0] FT_END_BYTES   = {8'h48, 8'h47, 8'h46, 8'h45};
  localparam logic [FT_MARKER_LEN-1:0][FT_BYTE_W-1:0] FT_PROC_BYTES  = {8'h63, 8'h6F, 8'h72, 8'h70};

  localparam logic [FT_BYTE_W-1:0] FT_CR = 8'h0D;
  localparam logic [FT_BYTE_W-1:0] FT_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1
`ifdef FT_MARKER_CRLF_EN
    ,ST_TRAIL = 2'd2
`endif
  } ft_state_e;

endpackage

// File: rtl/ft_marker_rom.sv
// Combinational marker byte lookup (id, index) -> byte; shared with the trigger decoder.
module ft_marker_rom
  import ft_marker_pkg::*;
(
  input  mk_id_e                i_id,
  input  logic [FT_IDX_W-1:0]   i_idx,
  output logic [FT_BYTE_W-1:0]  o_byte
);

  always_comb begin
    o_byte = '0;
    case (i_id)
      MK_START: o_byte = FT_START_BYTES[i_idx];
      MK_END:   o_byte = FT_END_BYTES[i_idx];
      MK_PROC:  o_byte = FT_PROC_BYTES[i_idx];
      default:  o_byte = '0;
    endcase
  end

endmodule

// File: rtl/ft_uart_marker_tx.sv
// Latches marker requests, arbitrates end > start > proc, and streams marker bytes into the
// UART TX FIFO under valid/ready. Define FT_MARKER_CRLF_EN to append CR LF after each marker.
module ft_uart_marker_tx
  import ft_marker_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_start,
  input  logic                 req_end,
  input  logic                 req_proc,
  output logic [FT_BYTE_W-1:0] tx_payload,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [2:0]           pending,
  output logic [7:0]           drop_count
);

  ft_state_e             r_state, w_state_nxt;
  mk_id_e                r_id, w_id_nxt, w_win_id, w_rom_id;
  logic [FT_IDX_W-1:0]   r_idx, w_idx_nxt, w_rom_idx;
  logic [FT_BYTE_W-1:0]  r_payload, w_payload_nxt, w_rom_byte;
  logic                  r_valid, w_valid_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [2:0]            r_pending, w_pending_nxt, w_req, w_clear, w_drop_vec;
  logic [7:0]            r_drop, w_drop_nxt;
  logic [1:0]            w_drop_inc;
  logic [8:0]            w_drop_sum;
  logic                  w_fire;

  assign w_req  = {req_proc, req_end, req_start};
  assign w_fire = r_valid & tx_ready;

  // Fixed priority: end > start > proc
  always_comb begin
    w_win_id = MK_PROC;
    if (r_pending[1])      w_win_id = MK_END;
    else if (r_pending[0]) w_win_id = MK_START;
  end

  // ROM is addressed with the byte that will be presented after this edge
  assign w_rom_id  = (r_state == ST_IDLE) ? w_win_id : r_id;
  assign w_rom_idx = (r_state == ST_IDLE) ? '0 : r_idx + FT_IDX_W'(1);

  ft_marker_rom u_rom (
    .i_id   (w_rom_id),
    .i_idx  (w_rom_idx),
    .o_byte (w_rom_byte)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_id_nxt      = r_id;
    w_idx_nxt     = r_idx;
    w_payload_nxt = r_payload;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_clear       = '0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_state_nxt   = ST_SEND;
          w_id_nxt      = w_win_id;
          w_idx_nxt     = '0;
          w_payload_nxt = w_rom_byte;
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
          w_clear       = 3'b001 << w_win_id;
        end
      end
      ST_SEND: begin
        if (w_fire) begin
          if (r_idx == FT_IDX_W'(FT_MARKER_LEN - 1)) begin
`ifdef FT_MARKER_CRLF_EN
            w_state_nxt   = ST_TRAIL;
            w_idx_nxt     = '0;
            w_payload_nxt = FT_CR;
`else
            w_state_nxt   = ST_IDLE;
            w_payload_nxt = '0;
            w_valid_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
`endif
          end else begin
            w_idx_nxt     = w_rom_idx;
            w_payload_nxt = w_rom_byte;
          end
        end
      end
`ifdef FT_MARKER_CRLF_EN
      ST_TRAIL: begin
        if (w_fire) begin
          if (r_idx == '0) begin
            w_idx_nxt     = FT_IDX_W'(1);
            w_payload_nxt = FT_LF;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_payload_nxt = '0;
            w_valid_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A request landing on the edge that loads the same marker re-arms it rather than coalescing
  always_comb begin
    w_pending_nxt = (r_pending & ~w_clear) | w_req;
    w_drop_vec    = w_req & r_pending & ~w_clear;
    w_drop_inc    = 2'(w_drop_vec[0]) + 2'(w_drop_vec[1]) + 2'(w_drop_vec[2]);
    w_drop_sum    = 9'(r_drop) + 9'(w_drop_inc);
    w_drop_nxt    = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_id      <= MK_START;
      r_idx     <= '0;
      r_payload <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= '0;
      r_drop    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_id      <= w_id_nxt;
      r_idx     <= w_idx_nxt;
      r_payload <= w_payload_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_pending <= w_pending_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  assign tx_payload = r_payload;
  assign tx_valid   = r_valid;
  assign busy       = r_busy;
  assign pending    = r_pending;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_ft_uart_marker_tx.sv
// Randomized bench for ft_uart_marker_tx against a marker-level reference model
// (markers as text strings, pending set with priority list, per-cycle handshake counting).
module tb_ft_uart_marker_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_start = 1'b0, req_end = 1'b0, req_proc = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_payload;
  logic       tx_valid;
  logic       busy;
  logic [2:0] pending;
  logic [7:0] drop_count;

  always #5 clock = ~clock;

  ft_uart_marker_tx dut (
    .clock      (clock),
    .reset      (reset),
    .req_start  (req_start),
    .req_end    (req_end),
    .req_proc   (req_proc),
    .tx_payload (tx_payload),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .pending    (pending),
    .drop_count (drop_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: pending set {proc,end,start}, drop total, in-flight marker and byte position
  logic [2:0] m_pend;
  int         m_drop;
  bit         m_active;
  int         m_id;
  int         m_k;

  function automatic string mk_text(input int id);
    string s;
    s = (id == 0) ? "ABCD" : (id == 1) ? "EFGH" : "proc";
`ifdef FT_MARKER_CRLF_EN
    s = {s, "\r\n"};
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend   = '0;
    m_drop   = 0;
    m_active = 1'b0;
    m_id     = 0;
    m_k      = 0;
  endtask

  task automatic model_step(input bit s, input bit e, input bit p, input bit rdy);
    logic [2:0] req, clr;
    int prio [3];
    string txt;
    prio = '{1, 0, 2};
    req  = {p, e, s};
    clr  = '0;
    if (!m_active) begin
      foreach (prio[i]) begin
        if (clr == 0 && m_pend[prio[i]]) begin
          clr[prio[i]] = 1'b1;
          m_id     = prio[i];
          m_k      = 0;
          m_active = 1'b1;
        end
      end
    end else if (rdy) begin
      txt = mk_text(m_id);
      if (m_k == txt.len() - 1) m_active = 1'b0;
      else m_k++;
    end
    m_drop = m_drop + $countones(req & m_pend & ~clr);
    if (m_drop > 255) m_drop = 255;
    m_pend = (m_pend & ~clr) | req;
  endtask

  task automatic compare_all();
    string txt;
    logic [7:0] exp_b;
    txt   = mk_text(m_id);
    exp_b = m_active ? txt[m_k] : 8'h00;
    chk("tx_valid", 32'(tx_valid), 32'(m_active));
    chk("tx_payload", 32'(tx_payload), 32'(exp_b));
    chk("busy", 32'(busy), 32'(m_active));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // Entered and left at posedge+1
  task automatic step(input bit s, input bit e, input bit p, input bit rdy);
    req_start = s;
    req_end   = e;
    req_proc  = p;
    tx_ready  = rdy;
    @(posedge clock);
    model_step(s, e, p, rdy);
    #1;
    compare_all();
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    hold_reset();

    // single start marker
    step(1, 0, 0, 1);
    repeat (7) step(0, 0, 0, 1);

    // three simultaneous requests: end, start, proc
    step(1, 1, 1, 1);
    repeat (20) step(0, 0, 0, 1);
    chk("drop_simul", 32'(drop_count), 32'd0);

    // proc marker stalled for 10 cycles on byte 0
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    chk("stall_byte0", 32'(tx_payload), 32'h70);
    repeat (6) step(0, 0, 0, 1);

    // coalescing while the FSM is stalled on a start marker, then saturation
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    chk("drop_two", 32'(drop_count), 32'd2);
    repeat (300) step(0, 1, 0, 0);
    chk("drop_sat", 32'(drop_count), 32'd255);
    repeat (15) step(0, 0, 0, 1);
    chk("drained", 32'(pending), 32'd0);

    // asynchronous reset in the middle of a start marker
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(tx_valid), 32'd0);
    chk("async_pending", 32'(pending), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    model_reset();
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1);

    // randomized requests and backpressure
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    repeat (40) step(0, 0, 0, 1);
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
